alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle execute-stage ALU. Generalises operand width, extends the command set with XOR/NOR/shifts and an iterative multiply, and adds zero/overflow flags. Registered valid/ready interfaces on both sides let the execute stage stall on multi-cycle operations.

## Interface
- `WORD_LEN`, 32: operand/result width; power of two, ≥ 8.
- `CMD_LEN`, 4: command width.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: command/operands valid.
- `in_ready` output, 1 bit: block can accept a command this cycle.
- `EXE_CMD` input, `CMD_LEN` bits: operation select.
- `val1`, `val2` input, `WORD_LEN` bits each: operands.
- `out_valid` output, 1 bit: result/flags valid.
- `out_ready` input, 1 bit: consumer takes the result this cycle.
- `aluOut` output, `WORD_LEN` bits: result, registered.
- `zero` output, 1 bit: `aluOut == 0`, registered.
- `ovf` output, 1 bit: signed overflow for ADD/SUB; 0 for all other commands.

## Operation
- **Command encodings:**
  - ADD=0, SUB=2, AND=4, OR=5, NOR=6, XOR=7.
  - SLL=8, SRL=9, SRA=10, MUL=12.
  - Any other code yields `aluOut`=0, `zero`=1, `ovf`=0 with single-cycle latency.
- **Arithmetic and width rules:**
  - ADD and SUB wrap modulo 2^`WORD_LEN`.
  - `ovf` is set when the operands' sign bits make a same-sign addition produce a different result sign. SUB is treated as `val1 + (~val2 + 1)`.
  - Shift amount is `val2[log2(WORD_LEN)-1:0]`; upper bits are ignored. SRA replicates `val1[WORD_LEN-1]`.
  - MUL returns the low `WORD_LEN` bits of `val1*val2`, which are identical for signed and unsigned. It uses one shift-add iteration per cycle on the multiplicand, the multiplier and an accumulator.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, operands are captured.
    - MUL goes to BUSY, the iteration counter is loaded with `WORD_LEN`, and the accumulator is cleared.
    - All other commands write `aluOut`/`zero`/`ovf` and go to DONE.
  - BUSY: `in_ready`=0. Each edge performs one iteration and decrements the counter. The edge where the counter reaches 0 writes the result and flags and goes to DONE.
  - DONE: `out_valid`=1; result and flags are held stable until `out_ready`.
    - `out_ready` with no new command goes to IDLE.
    - `in_ready` = `out_ready` in DONE. A simultaneous `in_valid && out_ready` drains the old result and accepts the new command on the same edge, following the IDLE rules.
- `in_valid` is ignored while `in_ready`=0. The upstream stage must hold operands stable until accepted.
- `out_ready` is ignored when `out_valid`=0.

## Timing
- **Reset:** while `rst` is low the state is IDLE and the outputs are `out_valid`=0, `aluOut`=0, `zero`=0, `ovf`=0, `in_ready`=0. `in_ready` rises in the first cycle after `rst` deasserts.
- **Non-MUL latency:** accepted at edge E0; `out_valid`=1 in the cycle after E0.
- **MUL latency:** accepted at E0; iterations run at E1..E`WORD_LEN`; `out_valid`=1 after E`WORD_LEN`.
- **Throughput:**
  - Non-MUL: one result per cycle while `out_ready` is held high.
  - MUL: one result per `WORD_LEN`+1 cycles.
- **Back-pressure:** `out_ready` low in DONE holds all outputs indefinitely; no command is lost or overwritten.
- **Reset mid-operation:** asserting `rst` in BUSY or DONE aborts immediately and discards the result. Nothing is emitted after reset.
- **Flag ordering:** flags change only on the edge that writes `aluOut`.

## Configuration
- `ALU_MUL_EN` defined: MUL is implemented as above, with a BUSY state, an iteration counter and an accumulator.
- `ALU_MUL_EN` undefined:
  - The multiplier logic and BUSY state are not compiled.
  - Code 12 is treated as an unknown command (result 0, `zero`=1, single-cycle).
  - `in_ready` never drops for computation.

## Test plan
- **Reset/idle:** hold `rst` low 3 cycles, release → `out_valid`=0, `aluOut`=0, `zero`=0, `ovf`=0 throughout reset; `in_ready`=1 in the first cycle after release.
- **ADD overflow:** `WORD_LEN`=32, ADD 0x7FFFFFFF+1 → `aluOut`=0x80000000, `ovf`=1, `zero`=0, `out_valid` one cycle after acceptance.
- **SUB to zero:** SUB 5-5 → `aluOut`=0, `zero`=1, `ovf`=0.
- **Shifts:**
  - SRA 0xF0000000 by 4 → 0xFF000000.
  - SRL 0xF0000000 by val2=0x24 (amount 4) → 0x0F000000.
- **MUL and stalling (`ALU_MUL_EN` defined):**
  - MUL 7×(-3) → 0xFFFFFFEB with `out_valid` after 32 edges; `in_ready`=0 during BUSY.
  - With `out_ready` low 5 cycles, the result is held unchanged.
  - Asserting `rst` at iteration 10 gives no output afterwards.
- **Back-to-back stream:** ADD, XOR, AND with `out_ready`=1 → one result per cycle in order.
  - With `ALU_MUL_EN` undefined, MUL 7×3 → 0 with `zero`=1, single-cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with flags and an iterative shift-add multiply.
// Define ALU_MUL_EN to build MUL; without it code 12 is an unknown command.
module alu_seq #(
  parameter int WORD_LEN = 32,
  parameter int CMD_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CMD_LEN-1:0]  EXE_CMD,
  input  logic [WORD_LEN-1:0] val1,
  input  logic [WORD_LEN-1:0] val2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] aluOut,
  output logic                zero,
  output logic                ovf
);
  localparam int SW = $clog2(WORD_LEN);
  localparam logic [1:0] IDLE = 2'd0, DONE = 2'd2;
  localparam logic [CMD_LEN-1:0] C_ADD = CMD_LEN'(0), C_SUB = CMD_LEN'(2), C_AND = CMD_LEN'(4),
                                 C_OR = CMD_LEN'(5), C_NOR = CMD_LEN'(6), C_XOR = CMD_LEN'(7),
                                 C_SLL = CMD_LEN'(8), C_SRL = CMD_LEN'(9), C_SRA = CMD_LEN'(10);
`ifdef ALU_MUL_EN
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [CMD_LEN-1:0] C_MUL = CMD_LEN'(12);
  localparam int CW = SW + 1;
  logic [WORD_LEN-1:0] mcand, mplier, acc, acc_nx;
  logic [CW-1:0]       cnt;
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif
  logic [1:0]          state;
  logic [WORD_LEN-1:0] b, sum, res;
  logic [SW-1:0]       sh;
  logic                accept, add_ovf, ovf_nx;
  // in_ready is held low by rst itself so it is 0 throughout reset
  assign in_ready  = rst && (state == IDLE || (state == DONE && out_ready));
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign sh        = val2[SW-1:0];
  assign b         = EXE_CMD == C_SUB ? ~val2 + WORD_LEN'(1) : val2;
  assign sum       = val1 + b;
  assign add_ovf   = (val1[WORD_LEN-1] == b[WORD_LEN-1]) && (sum[WORD_LEN-1] != val1[WORD_LEN-1]);
  assign ovf_nx    = (EXE_CMD == C_ADD || EXE_CMD == C_SUB) && add_ovf;
  always_comb begin
    res = '0;
    case (EXE_CMD)
      C_ADD, C_SUB: res = sum;
      C_AND:        res = val1 & val2;
      C_OR:         res = val1 | val2;
      C_NOR:        res = ~(val1 | val2);
      C_XOR:        res = val1 ^ val2;
      C_SLL:        res = val1 << sh;
      C_SRL:        res = val1 >> sh;
      C_SRA:        res = $unsigned($signed(val1) >>> sh);
      default:      res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      aluOut <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (EXE_CMD == C_MUL) begin
        state  <= BUSY;
        mcand  <= val1;
        mplier <= val2;
        acc    <= '0;
        cnt    <= CW'(WORD_LEN);
      end else
`endif
      begin
        state  <= DONE;
        aluOut <= res;
        zero   <= res == '0;
        ovf    <= ovf_nx;
      end
    end
`ifdef ALU_MUL_EN
    else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state  <= DONE;
        aluOut <= acc_nx;
        zero   <= acc_nx == '0;
        ovf    <= 1'b0;
      end
    end
`endif
    else if (state == DONE && out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WORD_LEN=32); MUL steps follow ALU_MUL_EN.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, zero, ovf;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1, val2, aluOut;
  int          tests = 0, fails = 0;

  alu_seq #(.WORD_LEN(32), .CMD_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .EXE_CMD(EXE_CMD),
    .val1(val1), .val2(val2), .out_valid(out_valid), .out_ready(out_ready),
    .aluOut(aluOut), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] bb,
                        input logic [31:0] er, input logic ez, input logic eo);
    EXE_CMD = cmd; val1 = a; val2 = bb; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, aluOut, er);
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int  n;
    logic seen;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; EXE_CMD = '0; val1 = '0; val2 = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_out", aluOut, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(in_ready), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);

    run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_zero", 4'd2, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    run_op("sub_ovf", 4'd2, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("sra", 4'd10, 32'hF0000000, 32'd4, 32'hFF000000, 1'b0, 1'b0);
    run_op("srl", 4'd9, 32'hF0000000, 32'h24, 32'h0F000000, 1'b0, 1'b0);
    run_op("sll", 4'd8, 32'h1, 32'd33, 32'h2, 1'b0, 1'b0);
    run_op("nor", 4'd6, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("and_noovf", 4'd4, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_op("unknown", 4'd3, 32'h12345678, 32'h1, 32'h0, 1'b1, 1'b0);

    // back-pressure on a single-cycle op, with a competing command held on the input
    EXE_CMD = 4'd5; val1 = 32'h12; val2 = 32'h21; in_valid = 1'b1;
    @(posedge clk); #1 EXE_CMD = 4'd0; val1 = 32'h1; val2 = 32'h1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_res", aluOut, 32'h33);
    chk("hold_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("hold_drain", 32'(out_valid), 32'd0);
    @(negedge clk);

    // back-to-back stream ADD, XOR, AND
    out_ready = 1'b1; EXE_CMD = 4'd0; val1 = 32'd1; val2 = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1 EXE_CMD = 4'd7; val1 = 32'hF0F0; val2 = 32'hFF00;
    @(negedge clk);
    chk("strm_add_v", 32'(out_valid), 32'd1);
    chk("strm_add", aluOut, 32'd3);
    chk("strm_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1 EXE_CMD = 4'd4;
    @(negedge clk);
    chk("strm_xor_v", 32'(out_valid), 32'd1);
    chk("strm_xor", aluOut, 32'h0FF0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("strm_and_v", 32'(out_valid), 32'd1);
    chk("strm_and", aluOut, 32'hF000);
    @(posedge clk); #1
    chk("strm_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);

`ifdef ALU_MUL_EN
    EXE_CMD = 4'd12; val1 = 32'd7; val2 = 32'hFFFFFFFD; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mul_busy_rdy", 32'(in_ready), 32'd0);
    chk("mul_busy_v", 32'(out_valid), 32'd0);
    n = 0; seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("mul_lat", 32'(n), 32'd32);
    chk("mul_rdy_low", 32'(seen), 32'd0);
    chk("mul_res", aluOut, 32'hFFFFFFEB);
    chk("mul_zero", 32'(zero), 32'd0);
    chk("mul_ovf", 32'(ovf), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mul_hold_v", 32'(out_valid), 32'd1);
    chk("mul_hold", aluOut, 32'hFFFFFFEB);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("mul_drain", 32'(out_valid), 32'd0);
    @(negedge clk);
    // reset partway through a multiply must discard it
    EXE_CMD = 4'd12; val1 = 32'd7; val2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_out", aluOut, 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_silent", 32'(seen), 32'd0);
    out_ready = 1'b0;
`else
    run_op("mul_off", 4'd12, 32'd7, 32'd3, 32'h0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
